i2c_ext_arb_master: RTL
=======================

I2C_EXT_ARB_MASTER -- requirements
Module: i2c_ext_arb_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, system clocks per quarter SCL bit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports req_valid[1:0], input, 2, per-requester transaction request.
REQ-005 SHALL have ports req_addr0 and req_addr1, input, 7 each, target slave address.
REQ-006 SHALL have ports req_data0 and req_data1, input, 8 each, write byte.
REQ-007 SHALL have port req_ready[1:0], output, 2, one-cycle accept strobe per requester.
REQ-008 SHALL have port done[1:0], output, 2, one-cycle completion strobe per requester.
REQ-009 SHALL have port nack, output, 1, valid with done; 1 = any ACK slot sampled high.
REQ-010 SHALL have port busy, output, 1, high from grant through end of STOP.
REQ-011 SHALL have port scl_o, output, 1, drives the extender's scl_in.
REQ-012 SHALL have port sda_o, output, 1, drives the extender's sda_in.
REQ-013 SHALL have port sda_i, input, 1, bus SDA readback for ACK sampling.

Function
REQ-014 SHALL advance all bus activity only on a tick: a one-clk strobe every CLK_DIV clocks, free-running while busy, restarted at grant.
REQ-015 SHALL use states IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE.
REQ-016 SHALL, in IDLE with any req_valid, grant in the same cycle: pulse req_ready for exactly one cycle, latch addr/data, enter START next cycle.
REQ-017 SHALL arbitrate round-robin: when both requesters are valid, the one not granted last wins; after reset requester 0 has priority.
REQ-018 SHALL ignore req_valid while busy; a requester SHALL hold req_valid until its req_ready.
REQ-019 SHALL spend 4 ticks per bit: q0 scl_o=0 and sda_o set; q1 scl_o=1; q2 scl_o=1 (ACK sampled); q3 scl_o=0.
REQ-020 SHALL generate START as sda_o 1->0 while scl_o=1 (4 ticks), and STOP as sda_o 0->1 while scl_o=1 (4 ticks).
REQ-021 SHALL send ADDR as {addr[6:0], 1'b0} MSB first (write only), then ACK1 with sda_o=1.
REQ-022 SHALL send DATA MSB first, then ACK2 with sda_o=1.
REQ-023 SHALL, on sda_i=1 at ACK1 q2, skip DATA/ACK2, go to STOP, and report nack=1.
REQ-024 SHALL, in DONE (one cycle), pulse done[granted]=1 with nack valid, then return to IDLE.
REQ-025 SHALL give an ACKed transaction 20 bit-times = 80 ticks from START entry to DONE.
REQ-026 SHALL hold nack at its last value until the next done; done and req_ready SHALL never be high together.
REQ-027 SHALL keep scl_o=1 and sda_o=1 in IDLE and DONE.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set state=IDLE, scl_o=1, sda_o=1, req_ready=0, done=0, nack=0, busy=0, priority=requester 0, tick counter=0.
REQ-029 SHALL abort a mid-transaction operation on reset with no STOP and no done pulse; the bus is released on the next cycle.

Structure
REQ-030 SHALL place the state enum, the bit-phase constants (q0..q3) and the bit-counter width in shared package i2c_ext_pkg.
REQ-031 SHALL implement the tick divider as sub-module i2c_tick_gen (param CLK_DIV; ports clk, rst, en, tick).

Verification
REQ-032 Single write: CLK_DIV=4, req0 addr=0x50 data=0xA5, sda_i ACKs -> SDA shows 0xA0 then 0xA5; done[0] after 320 clks from START; nack=0.
REQ-033 Address NACK: sda_i=1 at ACK1 -> no DATA bits, STOP follows ACK1, done[0]=1 with nack=1.
REQ-034 Simultaneous requests, both valid at reset release -> req0 served first, then req1; with both re-asserted, order alternates 0,1,0,1.
REQ-035 Data NACK: ACK1 low, ACK2 high -> full DATA sent, nack=1 at done.
REQ-036 Reset during DATA bit 3 -> next cycle scl_o=1, sda_o=1, busy=0, no done pulse; a new req1 is accepted afterwards.
REQ-037 Request during busy: req1 asserted mid-transfer -> req_ready[1] only after done[0], in IDLE.

Source files
------------

// File: rtl/i2c_ext_pkg.sv
// Shared types and constants for the arbitrated write-only I2C master that
// feeds an external bus extender.
package i2c_ext_pkg;

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE
    } state_e;

    localparam int BIT_CNT_W = 3;

    localparam logic [1:0] PH_Q0 = 2'd0;
    localparam logic [1:0] PH_Q1 = 2'd1;
    localparam logic [1:0] PH_Q2 = 2'd2;
    localparam logic [1:0] PH_Q3 = 2'd3;

    typedef struct packed {
        logic scl;
        logic sda;
    } bus_t;

    // SCL/SDA levels for a given state and quarter-bit phase.
    function automatic bus_t bus_level(state_e st, logic [1:0] ph, logic tx_bit);
        bus_t b;
        b.scl = 1'b1;
        b.sda = 1'b1;
        case (st)
            START: begin
                b.scl = (ph != PH_Q3);
                b.sda = (ph == PH_Q0);
            end
            ADDR, ACK1, DATA, ACK2: begin
                b.scl = (ph == PH_Q1) || (ph == PH_Q2);
                b.sda = tx_bit;
            end
            STOP: begin
                b.scl = (ph != PH_Q0);
                b.sda = (ph == PH_Q2) || (ph == PH_Q3);
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_ext_arb_master_tick.sv
// Quarter-bit strobe: one-cycle tick every CLK_DIV clocks while enabled,
// restarting from zero whenever the enable drops.
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt_q;

    assign tick = en && (cnt_q == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/i2c_ext_arb_master.sv
// Two-requester round-robin I2C write master: START, address+W, ACK, one
// data byte, ACK, STOP, paced by quarter-bit ticks.
module i2c_ext_arb_master
    import i2c_ext_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [6:0] req_addr0,
    input  logic [6:0] req_addr1,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic [1:0] done,
    output logic       nack,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i
);

    state_e                 state_q, state_d;
    logic [1:0]             phase_q, phase_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   nack_acc_q, nack_acc_d;
    logic                   last_q;
    logic                   owner_q;
    logic [6:0]             addr_q;
    logic [7:0]             data_q;
    logic                   scl_q, sda_q, busy_q, nack_q;
    logic [1:0]             done_q;

    logic                   tick;
    logic                   any_req;
    logic                   gnt_idx;
    logic [7:0]             addr_byte;
    logic                   tx_bit_d;
    bus_t                   bus_d;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy_q),
        .tick (tick)
    );

    // last_q holds the previous winner; on a tie the other requester wins.
    assign any_req   = |req_valid;
    assign gnt_idx   = (&req_valid) ? ~last_q : req_valid[1];
    assign req_ready = (!rst && state_q == IDLE && any_req) ?
                       (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign addr_byte = {addr_q, 1'b0};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        nack_acc_d = nack_acc_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = START;
                    phase_d    = PH_Q0;
                    bit_cnt_d  = '0;
                    nack_acc_d = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (tick) begin
                    if (phase_q == PH_Q2 && (state_q == ACK1 || state_q == ACK2) && sda_i) begin
                        nack_acc_d = 1'b1;
                    end
                    if (phase_q != PH_Q3) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        phase_d = PH_Q0;
                        case (state_q)
                            START: begin
                                state_d   = ADDR;
                                bit_cnt_d = '0;
                            end
                            ADDR: begin
                                if (bit_cnt_q == '1) state_d = ACK1;
                                else                 bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                            end
                            ACK1: begin
                                state_d   = nack_acc_q ? STOP : DATA;
                                bit_cnt_d = '0;
                            end
                            DATA: begin
                                if (bit_cnt_q == '1) state_d = ACK2;
                                else                 bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                            end
                            ACK2:    state_d = STOP;
                            STOP:    state_d = DONE;
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        tx_bit_d = 1'b1;
        if (state_d == ADDR)      tx_bit_d = addr_byte[~bit_cnt_d];
        else if (state_d == DATA) tx_bit_d = data_q[~bit_cnt_d];
        bus_d = bus_level(state_d, phase_d, tx_bit_d);
    end

    // NOTE: pin levels are registered from the next state so scl_o/sda_o are
    // glitch-free flop outputs that change in the same cycle as state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= PH_Q0;
            bit_cnt_q  <= '0;
            nack_acc_q <= 1'b0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 2'b00;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            nack_acc_q <= nack_acc_d;
            if (state_q == IDLE && any_req) begin
                owner_q <= gnt_idx;
                last_q  <= gnt_idx;
                addr_q  <= gnt_idx ? req_addr1 : req_addr0;
                data_q  <= gnt_idx ? req_data1 : req_data0;
            end
            scl_q  <= bus_d.scl;
            sda_q  <= bus_d.sda;
            busy_q <= (state_d != IDLE) && (state_d != DONE);
            done_q <= (state_d == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
            if (state_d == DONE) nack_q <= nack_acc_d;
        end
    end

    assign scl_o = scl_q;
    assign sda_o = sda_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign nack  = nack_q;

endmodule
